// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
package sar_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sar_search_4bit.sv
// Binary search driving an external comparator: one trial bit per TEST cycle,
// early exit on equality, error exit on any non-one-hot comparator code.
//
// state | meaning
// IDLE  | waiting for start, trial forced to 0
// TEST  | trial = acc | (1<<k) presented to comparator, decision taken this cycle
// DONE  | single-cycle completion, done pulses, result/found/err valid
module sar_search_4bit
    import sar_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_FIRST = KW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [KW-1:0]    k;
    logic [2:0]       cmp_code;
    logic             last_bit;

    assign cmp_code = {cmp_lt, cmp_gt, cmp_eq};
    assign last_bit = (k == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = TEST;
            TEST: begin
                case (cmp_code)
                    3'b001:         state_next = DONE;
                    3'b100, 3'b010: state_next = last_bit ? DONE : TEST;
                    default:        state_next = DONE;
                endcase
            end
            DONE:    state_next = start ? TEST : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        trial = '0;
        case (state)
            TEST: begin
                busy  = 1'b1;
                trial = acc | (WIDTH'(1) << k);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Search datapath; start is only honoured outside TEST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            k      <= K_FIRST;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        acc    <= '0;
                        k      <= K_FIRST;
                        result <= '0;
                        found  <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                TEST: begin
                    case (cmp_code)
                        3'b001: begin
                            result <= trial;
                            found  <= 1'b1;
                        end
                        3'b100: begin
                            acc <= trial;
                            if (last_bit) result <= trial;
                            else          k      <= k - 1'b1;
                        end
                        3'b010: begin
                            if (last_bit) result <= acc;
                            else          k      <= k - 1'b1;
                        end
                        default: begin
                            err    <= 1'b1;
                            result <= acc;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_4bit.sv
// Closed-loop bench: magnitude comparator model on trial, expected output
// timeline built from a plain binary-search model, checked every cycle.
module tb_sar_search_4bit;

    localparam int W = 4;

    typedef struct packed {
        logic         busy;
        logic         done;
        logic [W-1:0] trial;
        logic [W-1:0] result;
        logic         found;
        logic         err;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] trial;
    logic         cmp_lt, cmp_gt, cmp_eq;
    logic         busy, done, found, err;
    logic [W-1:0] result;

    logic [W-1:0] target;
    logic         force_bad;
    logic         cmp_en;

    int n_checks = 0;
    int n_pass   = 0;

    ent_t         exp_q[$];
    ent_t         mq[$];
    logic [W-1:0] held_result;
    logic         held_found, held_err;

    sar_search_4bit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .trial  (trial),
        .cmp_lt (cmp_lt),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (force_bad) begin
            cmp_lt = 1'b1;
            cmp_gt = 1'b1;
            cmp_eq = 1'b0;
        end else begin
            cmp_lt = (trial < target);
            cmp_gt = (trial > target);
            cmp_eq = (trial == target);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    // Expected per-cycle outputs of one search, from the bit-by-bit search rule.
    task automatic model_search(input logic [W-1:0] tgt, input int bad);
        int   acc;
        int   c;
        bit   fnd;
        bit   er;
        ent_t e;
        acc = 0;
        c   = 0;
        fnd = 0;
        er  = 0;
        mq.delete();
        for (int kk = W - 1; kk >= 0; kk--) begin
            int t;
            t = acc | (1 << kk);
            c++;
            e.busy = 1'b1; e.done = 1'b0; e.trial = t[W-1:0];
            e.result = '0; e.found = 1'b0; e.err = 1'b0;
            mq.push_back(e);
            if (c == bad) begin er = 1; break; end
            if (t == int'(tgt)) begin fnd = 1; acc = t; break; end
            if (t < int'(tgt)) acc = t;
        end
        e.busy = 1'b0; e.done = 1'b1; e.trial = '0;
        e.result = acc[W-1:0]; e.found = fnd; e.err = er;
        mq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            ent_t e;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.done) begin
                    held_result = e.result;
                    held_found  = e.found;
                    held_err    = e.err;
                end
            end else begin
                e.busy = 1'b0; e.done = 1'b0; e.trial = '0;
                e.result = held_result; e.found = held_found; e.err = held_err;
            end
            chk("cyc_busy",   busy,   e.busy);
            chk("cyc_done",   done,   e.done);
            chk("cyc_trial",  trial,  e.trial);
            chk("cyc_result", result, e.result);
            chk("cyc_found",  found,  e.found);
            chk("cyc_err",    err,    e.err);
        end
    end

    // Leaves the caller in the DONE cycle, just after the clock edge.
    task automatic search(input logic [W-1:0] tgt, input int bad, input bit poke);
        int n;
        target = tgt;
        start  = 1'b1;
        @(posedge clk);
        model_search(tgt, bad);
        foreach (mq[i]) exp_q.push_back(mq[i]);
        n = mq.size() - 1;
        #1;
        for (int c = 1; c <= n; c++) begin
            force_bad = (c == bad);
            start     = (poke && c == 2);
            @(posedge clk);
            #1;
        end
        force_bad = 1'b0;
        start     = 1'b0;
    endtask

    task automatic idle(input int m);
        repeat (m) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_trial"},  trial,  0);
        chk({name, "_busy"},   busy,   0);
        chk({name, "_done"},   done,   0);
        chk({name, "_result"}, result, 0);
        chk({name, "_found"},  found,  0);
        chk({name, "_err"},    err,    0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        force_bad   = 1'b0;
        target      = '0;
        cmp_en      = 1'b0;
        held_result = '0;
        held_found  = 1'b0;
        held_err    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        idle(1);

        // Pin the model itself against hand-derived sequences.
        model_search(4'd11, 0);
        chk("model11_len", mq.size(), 5);
        chk("model11_t0", mq[0].trial, 8);
        chk("model11_t1", mq[1].trial, 12);
        chk("model11_t2", mq[2].trial, 10);
        chk("model11_t3", mq[3].trial, 11);
        chk("model11_res", {mq[4].result, mq[4].found, mq[4].err}, {4'd11, 1'b1, 1'b0});
        model_search(4'd0, 0);
        chk("model0_trials", {mq[0].trial, mq[1].trial, mq[2].trial, mq[3].trial},
            {4'd8, 4'd4, 4'd2, 4'd1});
        chk("model0_res", {mq[4].result, mq[4].found, mq[4].err}, {4'd0, 1'b0, 1'b0});
        model_search(4'd11, 2);
        chk("model_err_res", {mq[2].result, mq[2].found, mq[2].err}, {4'd8, 1'b0, 1'b1});

        search(4'd11, 0, 0);
        chk("t11_done", done, 1);
        chk("t11_out", {result, found, err}, {4'd11, 1'b1, 1'b0});
        idle(2);

        search(4'd8, 0, 0);
        chk("t8_out", {done, result, found, err}, {1'b1, 4'd8, 1'b1, 1'b0});
        idle(1);

        search(4'd0, 0, 0);
        chk("t0_out", {done, result, found, err}, {1'b1, 4'd0, 1'b0, 1'b0});
        idle(2);

        search(4'd11, 2, 0);
        chk("bad_out", {done, result, found, err}, {1'b1, 4'd8, 1'b0, 1'b1});
        idle(1);

        // Abort in the third TEST cycle.
        target = 4'd11;
        start  = 1'b1;
        @(posedge clk);
        model_search(4'd11, 0);
        foreach (mq[i]) exp_q.push_back(mq[i]);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_zero("abort");
        exp_q.delete();
        held_result = '0;
        held_found  = 1'b0;
        held_err    = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        idle(2);

        search(4'd5, 0, 0);
        chk("t5_out", {done, result, found, err}, {1'b1, 4'd5, 1'b1, 1'b0});
        idle(1);

        // Start pulse mid-search is ignored, then back-to-back restarts from DONE.
        search(4'd11, 0, 1);
        chk("poke_out", {done, result, found}, {1'b1, 4'd11, 1'b1});
        search(4'd6, 0, 0);
        chk("b2b6_out", {done, result, found, err}, {1'b1, 4'd6, 1'b1, 1'b0});
        search(4'd15, 0, 0);
        chk("b2b15_out", {done, result, found, err}, {1'b1, 4'd15, 1'b1, 1'b0});
        idle(3);

        if (exp_q.size() != 0) chk("exp_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
